tratador_botoes: RTL and testbench

//  Consumes the 12-bit active-high button vector from the 6-button joypad reader (Controle.Saidas).

---
 rtl/tratador_botoes_pkg.sv | 27 ++
 rtl/tratador_botoes_repetidor.sv | 75 +++++++
 rtl/tratador_botoes.sv | 102 ++++++++++
 tb/tb_tratador_botoes.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tratador_botoes_pkg.sv
// Shared definitions for the joypad button handler.
// Button bit map and the direction repeat FSM states.
package tratador_botoes_pkg;

  localparam int N_BTN = 12;
  localparam int N_DIR = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  typedef enum logic [1:0] {
    OCIOSO,
    ATRASO,
    REPETINDO
  } rep_estado_t;

endpackage

// File: rtl/tratador_botoes_repetidor.sv
// Auto-repeat FSM for one direction, counted in frames.
// Pulse is registered and lands in the frame's update cycle.
module repetidor_direcao
  import tratador_botoes_pkg::*;
#(
  parameter int ATRASO_REPETICAO  = 20,
  parameter int PERIODO_REPETICAO = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic press_i,
  input  logic level_i,
  input  logic inhibit_i,
  output logic pulse_o
);

  localparam logic [5:0] ATR_FIM = 6'(ATRASO_REPETICAO - 1);
  localparam logic [5:0] PER_FIM = 6'(PERIODO_REPETICAO - 1);

  rep_estado_t st_q;
  logic [5:0]  cnt_q;
  logic        pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= OCIOSO;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (tick_i) begin
        // release or opposing pair beats any due repeat
        if (!level_i || inhibit_i) begin
          st_q  <= OCIOSO;
          cnt_q <= '0;
        end else begin
          unique case (st_q)
            OCIOSO: begin
              if (press_i) begin
                pulse_q <= 1'b1;
                st_q    <= ATRASO;
                cnt_q   <= '0;
              end
            end
            ATRASO: begin
              if (cnt_q == ATR_FIM) begin
                pulse_q <= 1'b1;
                st_q    <= REPETINDO;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            REPETINDO: begin
              if (cnt_q == PER_FIM) begin
                pulse_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            default: begin
              st_q  <= OCIOSO;
              cnt_q <= '0;
            end
          endcase
        end
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/tratador_botoes.sv
// Frame-synchronous debounce of the joypad vector with
// press/release pulses and direction auto-repeat.
module tratador_botoes
  import tratador_botoes_pkg::*;
#(
  parameter int ESTAVEL           = 2,
  parameter int ATRASO_REPETICAO  = 20,
  parameter int PERIODO_REPETICAO = 5
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        v_sync,
  input  logic [11:0] Saidas,
  output logic [11:0] Estado,
  output logic [11:0] Pressionado,
  output logic [11:0] Solto,
  output logic [3:0]  Repetir,
  output logic        NovoQuadro
);

  localparam logic [2:0] EST_FIM = 3'(ESTAVEL - 1);

  logic                   sa_q, sb_q;
  logic                   flag;
  logic [N_BTN-1:0]       estado_q, estado_d;
  logic [N_BTN-1:0][2:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0]       press_q, press_d;
  logic [N_BTN-1:0]       solto_q, solto_d;
  logic                   novo_q;
  logic                   ud, lr;
  logic [N_DIR-1:0]       inib;

  assign flag = !sa_q && sb_q;

  // Saidas is read directly in the flag cycle; results register
  // into the update cycle.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    press_d  = '0;
    solto_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (Saidas[i] == estado_q[i]) begin
        cnt_d[i] = 3'd0;
      end else if (cnt_q[i] == EST_FIM) begin
        estado_d[i] = Saidas[i];
        cnt_d[i]    = 3'd0;
        press_d[i]  = Saidas[i];
        solto_d[i]  = !Saidas[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      sa_q     <= 1'b1;
      sb_q     <= 1'b1;
      estado_q <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      solto_q  <= '0;
      novo_q   <= 1'b0;
    end else begin
      sa_q    <= v_sync;
      sb_q    <= sa_q;
      novo_q  <= flag;
      press_q <= flag ? press_d : '0;
      solto_q <= flag ? solto_d : '0;
      if (flag) begin
        estado_q <= estado_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  assign ud   = estado_d[BTN_UP] & estado_d[BTN_DOWN];
  assign lr   = estado_d[BTN_LEFT] & estado_d[BTN_RIGHT];
  assign inib = {lr, lr, ud, ud};

  for (genvar d = 0; d < N_DIR; d++) begin : g_rep
    repetidor_direcao #(
      .ATRASO_REPETICAO (ATRASO_REPETICAO),
      .PERIODO_REPETICAO(PERIODO_REPETICAO)
    ) u_rep (
      .clk_i    (Clock50),
      .rst_i    (Reset),
      .tick_i   (flag),
      .press_i  (press_d[d]),
      .level_i  (estado_d[d]),
      .inhibit_i(inib[d]),
      .pulse_o  (Repetir[d])
    );
  end

  assign Estado      = estado_q;
  assign Pressionado = press_q;
  assign Solto       = solto_q;
  assign NovoQuadro  = novo_q;

endmodule

// File: tb/tb_tratador_botoes.sv
// Scoreboard bench: per-frame reference model feeds a queue,
// a monitor checks every NovoQuadro against it.
module tb_tratador_botoes;

  localparam int EST = 2;
  localparam int ATR = 20;
  localparam int PER = 5;

  typedef struct packed {
    logic [11:0] est;
    logic [11:0] prs;
    logic [11:0] sol;
    logic [3:0]  rep;
  } exp_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        vs  = 1;
  logic [11:0] sai = '0;
  logic [11:0] est_o, prs_o, sol_o;
  logic [3:0]  rep_o;
  logic        nq_o;

  int tests = 0;
  int fails = 0;
  int rep0_cnt = 0;
  exp_t q[$];

  // reference model state
  logic [11:0] m_est;
  int          m_run [12];
  bit          armed [4];
  int          age   [4];

  tratador_botoes #(
    .ESTAVEL(EST),
    .ATRASO_REPETICAO(ATR),
    .PERIODO_REPETICAO(PER)
  ) dut (
    .Clock50(clk),
    .Reset(rst),
    .v_sync(vs),
    .Saidas(sai),
    .Estado(est_o),
    .Pressionado(prs_o),
    .Solto(sol_o),
    .Repetir(rep_o),
    .NovoQuadro(nq_o)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    m_est = '0;
    for (int i = 0; i < 12; i++) m_run[i] = 0;
    for (int d = 0; d < 4; d++) begin
      armed[d] = 0;
      age[d] = 0;
    end
    q.delete();
  endtask

  task automatic model_frame(input logic [11:0] s);
    exp_t e;
    bit ud, lr, inh;
    e = '0;
    for (int i = 0; i < 12; i++) begin
      if (s[i] != m_est[i]) begin
        m_run[i]++;
        if (m_run[i] >= EST) begin
          m_est[i] = s[i];
          m_run[i] = 0;
          if (s[i]) e.prs[i] = 1;
          else e.sol[i] = 1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    ud = m_est[0] && m_est[1];
    lr = m_est[2] && m_est[3];
    for (int d = 0; d < 4; d++) begin
      inh = (d < 2) ? ud : lr;
      if (!m_est[d] || inh) begin
        armed[d] = 0;
      end else if (e.prs[d]) begin
        armed[d] = 1;
        age[d] = 0;
        e.rep[d] = 1;
      end else if (armed[d]) begin
        age[d]++;
        if (age[d] == ATR ||
            (age[d] > ATR && (age[d] - ATR) % PER == 0))
          e.rep[d] = 1;
      end
    end
    e.est = m_est;
    q.push_back(e);
  endtask

  task automatic frame(input logic [11:0] s);
    sai = s;
    model_frame(s);
    vs = 0;
    repeat (4) @(negedge clk);
    vs = 1;
    repeat (8) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL frame_done: %0d pending, required 0",
               q.size());
      q.delete();
    end
  endtask

  task automatic frames(input logic [11:0] s, input int n);
    for (int k = 0; k < n; k++) frame(s);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    logic [40:0] got;
    got = {est_o, prs_o, sol_o, rep_o, nq_o};
    tests++;
    if (got != '0) begin
      fails++;
      $display("FAIL %s: outputs %h, required 0", nm, got);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (nq_o) begin
        if (rep_o[0]) rep0_cnt++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL novoquadro: unexpected pulse, none required");
        end else begin
          e = q.pop_front();
          tests += 4;
          if (est_o != e.est) begin
            fails++;
            $display("FAIL estado: got %h required %h", est_o, e.est);
          end
          if (prs_o != e.prs) begin
            fails++;
            $display("FAIL press: got %h required %h", prs_o, e.prs);
          end
          if (sol_o != e.sol) begin
            fails++;
            $display("FAIL solto: got %h required %h", sol_o, e.sol);
          end
          if (rep_o != e.rep) begin
            fails++;
            $display("FAIL repetir: got %h required %h", rep_o, e.rep);
          end
        end
      end else if ((prs_o | sol_o) != '0 || rep_o != '0) begin
        tests++;
        fails++;
        $display("FAIL stray: prs %h sol %h rep %h, required 0",
                 prs_o, sol_o, rep_o);
      end
    end
  end

  initial begin
    logic [11:0] cur;
    int r0;
    model_reset();
    @(negedge clk);
    do_reset();

    // idle with v_sync high
    repeat (40) @(negedge clk);
    check_idle("reset_idle");

    // A held, then released
    frames(12'h010, 2);
    frames(12'h000, 3);

    // Start glitch of one frame
    frame(12'h400);
    frames(12'h000, 3);

    // Up held 40 frames
    r0 = rep0_cnt;
    frames(12'h001, 40);
    tests++;
    if (rep0_cnt - r0 != 5) begin
      fails++;
      $display("FAIL up_repeats: got %0d required 5",
               rep0_cnt - r0);
    end
    frames(12'h000, 4);

    // Left, then Left+Right, release Right, re-press Left
    frames(12'h004, 3);
    frames(12'h00C, 6);
    frames(12'h004, 25);
    frames(12'h000, 3);
    frames(12'h004, 25);
    frames(12'h000, 3);

    // Down, reset mid-ATRASO, Down still held
    frames(12'h002, 10);
    sai = 12'h002;
    do_reset();
    check_idle("reset_mid_atraso");
    frames(12'h002, 25);
    frames(12'h000, 3);

    // randomized button activity
    cur = '0;
    for (int k = 0; k < 250; k++) begin
      for (int b = 0; b < 12; b++)
        if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      frame(cur);
    end
    frames(12'h000, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
